// File: rtl/shake_squeeze_streamer.sv
// SHAKE256 squeeze-side streamer: snapshots the 1088-bit rate, emits 64-bit words over valid/ready, requests extra permutations for XOF output.
// Optional SQUEEZE_KEEP_EN adds o_dout_keep (raw dout); without it unused bytes of the final word are zeroed.
module shake_squeeze_streamer #(
    parameter int WORD_W    = 64,
    parameter int RATE_BITS = 1088,
    parameter int LEN_W     = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [LEN_W-1:0]     i_out_len,
    input  logic                 i_squeeze,
    input  logic [RATE_BITS-1:0] i_state_rate,
    input  logic                 i_perm_done,
    output logic                 o_perm_req,
    output logic [WORD_W-1:0]    o_dout,
    output logic                 o_dout_valid,
    input  logic                 i_dout_ready,
    output logic                 o_dout_last,
    output logic                 o_busy,
    output logic                 o_done
`ifdef SQUEEZE_KEEP_EN
   ,output logic [7:0]           o_dout_keep
`endif
);

    // state     | meaning
    // IDLE      | waiting for start
    // WAIT_SQ   | request latched, waiting for squeeze to snapshot the rate
    // STREAM    | presenting snapshot words on dout
    // PERM_WAIT | block exhausted, waiting for the extra permutation
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_SQ   = 3'd1,
        S_STREAM    = 3'd2,
        S_PERM_WAIT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam int             RATE_WORDS = RATE_BITS / WORD_W;
    localparam logic [4:0]     LAST_IDX   = 5'(RATE_WORDS - 1);
    localparam logic [LEN_W-1:0] BPW      = LEN_W'(WORD_W / 8);

    state_t                 r_state, w_state_nx;
    logic [LEN_W-1:0]       r_rem, w_rem_nx, w_rem_dec, w_sel_rem;
    logic [4:0]             r_idx, w_idx_nx, w_sel_idx;
    logic [RATE_BITS-1:0]   r_snap;
    logic [WORD_W-1:0]      r_dout, w_dout_nx, w_word;
    logic                   r_valid, w_valid_nx;
    logic                   r_last, w_last_nx;
    logic                   r_perm_req, w_perm_req_nx;
    logic                   w_snap_ld, w_load;
    logic [7:0]             w_sel_keep;
`ifdef SQUEEZE_KEEP_EN
    logic [7:0]             r_keep, w_keep_nx;
`endif

    function automatic logic [7:0] keep_of(input logic [LEN_W-1:0] rem);
        if (rem >= BPW)
            return 8'hFF;
        else
            return 8'hFF >> (4'd8 - rem[3:0]);
    endfunction

    assign w_rem_dec = (r_rem <= BPW) ? '0 : r_rem - BPW;

    always_comb begin
        w_state_nx    = r_state;
        w_rem_nx      = r_rem;
        w_idx_nx      = r_idx;
        w_snap_ld     = 1'b0;
        w_valid_nx    = r_valid;
        w_last_nx     = r_last;
        w_dout_nx     = r_dout;
        w_perm_req_nx = 1'b0;
        w_load        = 1'b0;
        w_sel_idx     = r_idx;
        w_sel_rem     = r_rem;
        w_word        = '0;
        w_sel_keep    = 8'h00;
`ifdef SQUEEZE_KEEP_EN
        w_keep_nx     = r_keep;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_out_len == '0) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_rem_nx   = i_out_len;
                        w_state_nx = S_WAIT_SQ;
                    end
                end
            end
            S_WAIT_SQ: begin
                if (i_squeeze) begin
                    w_snap_ld  = 1'b1;
                    w_idx_nx   = 5'd0;
                    w_state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!r_valid) begin
                    w_load = 1'b1;
                end else if (i_dout_ready) begin
                    w_rem_nx   = w_rem_dec;
                    w_valid_nx = 1'b0;
                    w_last_nx  = 1'b0;
                    if (r_rem <= BPW) begin
                        w_state_nx = S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        w_perm_req_nx = 1'b1;
                        w_state_nx    = S_PERM_WAIT;
                    end else begin
                        // Preload the next word on the transfer edge for 1 word/cycle.
                        w_idx_nx  = r_idx + 5'd1;
                        w_sel_idx = r_idx + 5'd1;
                        w_sel_rem = w_rem_dec;
                        w_load    = 1'b1;
                    end
                end
            end
            S_PERM_WAIT: begin
                if (i_perm_done && i_squeeze) begin
                    w_snap_ld  = 1'b1;
                    w_idx_nx   = 5'd0;
                    w_state_nx = S_STREAM;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_word     = r_snap[32'(w_sel_idx) * WORD_W +: WORD_W];
            w_sel_keep = keep_of(w_sel_rem);
            w_valid_nx = 1'b1;
            w_last_nx  = (w_sel_rem <= BPW);
`ifdef SQUEEZE_KEEP_EN
            w_keep_nx  = w_sel_keep;
            w_dout_nx  = w_word;
`else
            for (int b = 0; b < WORD_W / 8; b++)
                w_dout_nx[b*8 +: 8] = w_sel_keep[b] ? w_word[b*8 +: 8] : 8'h00;
`endif
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_idx      <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_perm_req <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_rem      <= w_rem_nx;
            r_idx      <= w_idx_nx;
            r_dout     <= w_dout_nx;
            r_valid    <= w_valid_nx;
            r_last     <= w_last_nx;
            r_perm_req <= w_perm_req_nx;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_snap <= '0;
        else if (w_snap_ld)
            r_snap <= i_state_rate;
    end

`ifdef SQUEEZE_KEEP_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_keep <= 8'h00;
        else
            r_keep <= w_keep_nx;
    end
    assign o_dout_keep = r_keep;
`endif

    assign o_perm_req   = r_perm_req;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_valid;
    assign o_dout_last  = r_last;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_shake_squeeze_streamer.sv
// Scoreboard bench for shake_squeeze_streamer: stimulus pushes expected words, a negedge monitor pops on each transfer.
module tb_shake_squeeze_streamer;

    localparam int LEN_W     = 16;
    localparam int RATE_BITS = 1088;

    logic                 i_clock = 1'b0;
    logic                 i_reset = 1'b1;
    logic                 i_start = 1'b0;
    logic [LEN_W-1:0]     i_out_len = '0;
    logic                 i_squeeze = 1'b1;
    logic [RATE_BITS-1:0] i_state_rate = '0;
    logic                 i_perm_done = 1'b0;
    logic                 o_perm_req;
    logic [63:0]          o_dout;
    logic                 o_dout_valid;
    logic                 i_dout_ready = 1'b1;
    logic                 o_dout_last;
    logic                 o_busy;
    logic                 o_done;
`ifdef SQUEEZE_KEEP_EN
    logic [7:0]           o_dout_keep;
`endif

    shake_squeeze_streamer dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_out_len    (i_out_len),
        .i_squeeze    (i_squeeze),
        .i_state_rate (i_state_rate),
        .i_perm_done  (i_perm_done),
        .o_perm_req   (o_perm_req),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid),
        .i_dout_ready (i_dout_ready),
        .o_dout_last  (o_dout_last),
        .o_busy       (o_busy),
        .o_done       (o_done)
`ifdef SQUEEZE_KEEP_EN
       ,.o_dout_keep  (o_dout_keep)
`endif
    );

    always #5 i_clock = ~i_clock;

    typedef struct packed {
        logic [63:0] d;
        logic        last;
        logic [7:0]  keep;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pop    = 0;
    int   n_perm   = 0;
    int   n_done   = 0;

    logic        prev_stall = 1'b0;
    logic [63:0] held_dout;
    logic        held_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Rate word i: seed in the top half, C0DE marker, index byte, inverted index in byte 0.
    function automatic logic [63:0] rw(input logic [31:0] seed, input int i);
        logic [7:0] ib;
        ib = 8'(i);
        return {seed, 16'hC0DE, ib, ~ib};
    endfunction

    task automatic load_rate(input logic [31:0] seed);
        for (int i = 0; i < 17; i++)
            i_state_rate[i*64 +: 64] = rw(seed, i);
    endtask

    task automatic push(input logic [31:0] seed, input int i, input int nbytes, input logic last);
        exp_t e;
        logic [63:0] w;
        logic [63:0] m;
        w = rw(seed, i);
        m = (nbytes >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (8 * nbytes)) - 64'h1);
        e.keep = (nbytes >= 8) ? 8'hFF : 8'((9'h1 << nbytes) - 9'h1);
`ifdef SQUEEZE_KEEP_EN
        e.d = w;
`else
        e.d = w & m;
`endif
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            if (o_done) got = 1'b1;
            else tick();
        end
        check(name, 64'(got), 64'h1);
        tick();
        check({name, "_pulse"}, 64'(o_done), 64'h0);
        check({name, "_busy"}, 64'(o_busy), 64'h0);
    endtask

    always @(negedge i_clock) begin
        if (i_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (o_perm_req) n_perm++;
            if (o_done) n_done++;
            if (prev_stall) begin
                check("stall_valid", 64'(o_dout_valid), 64'h1);
                check("stall_dout", o_dout, held_dout);
                check("stall_last", 64'(o_dout_last), 64'(held_last));
            end
            prev_stall = o_dout_valid && !i_dout_ready;
            held_dout  = o_dout;
            held_last  = o_dout_last;
            if (o_dout_valid && i_dout_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h expected no transfer", o_dout);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("dout", o_dout, e.d);
                    check("dout_last", 64'(o_dout_last), 64'(e.last));
`ifdef SQUEEZE_KEEP_EN
                    check("dout_keep", 64'(o_dout_keep), 64'(e.keep));
`endif
                end
                n_pop++;
            end
        end
    end

    initial begin
        int base_perm, base_done, base_pop, bc;
        logic got;

        repeat (3) tick();
        check("rst_perm_req", 64'(o_perm_req), 64'h0);
        check("rst_dout", o_dout, 64'h0);
        check("rst_valid", 64'(o_dout_valid), 64'h0);
        check("rst_last", 64'(o_dout_last), 64'h0);
        check("rst_busy", 64'(o_busy), 64'h0);
        check("rst_done", 64'(o_done), 64'h0);
        i_reset = 1'b0;
        tick();

        // 32 bytes: four full words, latency and no permutation.
        load_rate(32'hA5A5_0001);
        for (int i = 0; i < 4; i++) push(32'hA5A5_0001, i, 8, i == 3);
        base_perm = n_perm;
        i_out_len = 16'd32;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        check("lat_c1_valid", 64'(o_dout_valid), 64'h0);
        check("lat_c1_busy", 64'(o_busy), 64'h1);
        tick();
        check("lat_c2_valid", 64'(o_dout_valid), 64'h0);
        tick();
        check("lat_c3_valid", 64'(o_dout_valid), 64'h1);
        wait_done(50, "len32_done");
        check("len32_perm", 64'(n_perm - base_perm), 64'h0);
        check("len32_sb_empty", 64'(sb.size()), 64'h0);

        // 136 bytes: exactly one rate block.
        load_rate(32'h1357_9BDF);
        for (int i = 0; i < 17; i++) push(32'h1357_9BDF, i, 8, i == 16);
        base_perm = n_perm;
        i_out_len = 16'd136;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        wait_done(100, "len136_done");
        check("len136_perm", 64'(n_perm - base_perm), 64'h0);
        check("len136_sb_empty", 64'(sb.size()), 64'h0);

        // 137 bytes: one block, one permutation, one 1-byte word.
        load_rate(32'hCAFE_0137);
        for (int i = 0; i < 17; i++) push(32'hCAFE_0137, i, 8, 1'b0);
        push(32'hBEEF_0002, 0, 1, 1'b1);
        base_perm = n_perm;
        i_out_len = 16'd137;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if (o_perm_req) got = 1'b1;
            else tick();
        end
        check("len137_perm_req_seen", 64'(got), 64'h1);
        check("len137_words_before_perm", 64'(sb.size()), 64'h1);
        repeat (30) tick();
        check("len137_wait_valid", 64'(o_dout_valid), 64'h0);
        load_rate(32'hBEEF_0002);
        i_perm_done = 1'b1;
        tick();
        i_perm_done = 1'b0;
        wait_done(50, "len137_done");
        check("len137_perm_count", 64'(n_perm - base_perm), 64'h1);
        check("len137_sb_empty", 64'(sb.size()), 64'h0);

        // Backpressure on word 2 of a 32-byte request.
        load_rate(32'h0BAD_F00D);
        for (int i = 0; i < 4; i++) push(32'h0BAD_F00D, i, 8, i == 3);
        base_pop  = n_pop;
        i_out_len = 16'd32;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (o_dout_valid && n_pop == base_pop + 2) got = 1'b1;
            else tick();
        end
        check("bp_word2_reached", 64'(got), 64'h1);
        i_dout_ready = 1'b0;
        repeat (3) tick();
        check("bp_no_pop_while_stalled", 64'(n_pop - base_pop), 64'h2);
        i_dout_ready = 1'b1;
        wait_done(50, "bp_done");
        check("bp_sb_empty", 64'(sb.size()), 64'h0);

        // Zero-length request.
        base_done = n_done;
        base_pop  = n_pop;
        i_out_len = 16'd0;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        check("len0_done_now", 64'(o_done), 64'h1);
        bc = 0;
        for (int k = 0; k < 6; k++) begin
            if (o_busy) bc++;
            tick();
        end
        check("len0_busy_cycles", 64'(bc), 64'h1);
        check("len0_done_count", 64'(n_done - base_done), 64'h1);
        check("len0_no_words", 64'(n_pop - base_pop), 64'h0);

        // Reset during word 5 of a 64-byte request, then a normal 8-byte request.
        load_rate(32'hDEAD_0064);
        for (int i = 0; i < 8; i++) push(32'hDEAD_0064, i, 8, i == 7);
        base_pop  = n_pop;
        i_out_len = 16'd64;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            if (o_dout_valid && n_pop == base_pop + 5) got = 1'b1;
            else tick();
        end
        check("mid_word5_reached", 64'(got), 64'h1);
        base_done = n_done;
        i_reset = 1'b1;
        #1;
        check("mid_rst_perm_req", 64'(o_perm_req), 64'h0);
        check("mid_rst_dout", o_dout, 64'h0);
        check("mid_rst_valid", 64'(o_dout_valid), 64'h0);
        check("mid_rst_last", 64'(o_dout_last), 64'h0);
        check("mid_rst_busy", 64'(o_busy), 64'h0);
        check("mid_rst_done", 64'(o_done), 64'h0);
`ifdef SQUEEZE_KEEP_EN
        check("mid_rst_keep", 64'(o_dout_keep), 64'h0);
`endif
        sb.delete();
        repeat (2) tick();
        i_reset = 1'b0;
        repeat (3) tick();
        check("mid_no_done", 64'(n_done - base_done), 64'h0);

        load_rate(32'h0000_0008);
        push(32'h0000_0008, 0, 8, 1'b1);
        base_pop  = n_pop;
        i_out_len = 16'd8;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        wait_done(50, "len8_done");
        check("len8_words", 64'(n_pop - base_pop), 64'h1);
        check("len8_sb_empty", 64'(sb.size()), 64'h0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/shake_squeeze_streamer.md
Name: shake_squeeze_streamer

Overview:
Output side of the SHAKE256 core. Once the control unit enters SQUEEZE, this block snapshots the 1088-bit rate portion of the Keccak state. It streams the snapshot to a downstream consumer as 64-bit words over a valid/ready handshake. When a requested output length exceeds one rate block, it requests additional permutations and continues streaming (XOF mode).

Parameters:
WORD_W, 64, output word width in bits; fixed at 64, other values unsupported
RATE_BITS, 1088, SHAKE256 rate; RATE_WORDS = RATE_BITS/WORD_W = 17
LEN_W, 16, width of the requested output length in bytes

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin output; sampled only in IDLE
out_len  in  LEN_W  requested output length in bytes, latched on start
squeeze  in  1  high while the control unit is in SQUEEZE (state valid)
state_rate  in  RATE_BITS  rate lanes of the Keccak state; word i = bits [64i+63:64i]
perm_done  in  1  one-cycle pulse: the requested extra permutation is complete and state_rate is updated
perm_req  out  1  one-cycle pulse requesting another 24-round permutation
dout  out  WORD_W  output word, little-endian byte order
dout_valid  out  1  dout holds a valid word
dout_ready  in  1  consumer accepts the word; transfer = dout_valid & dout_ready
dout_last  out  1  qualifies the final word of the request
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the request completes

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. All outputs are 0: perm_req, dout, dout_valid, dout_last, busy, done. Counters and snapshot are cleared. Reset mid-stream abandons the request with no done pulse.
- States: IDLE, WAIT_SQ, STREAM, PERM_WAIT, DONE.
- IDLE, start=1:
  - out_len==0 -> DONE.
  - Otherwise latch rem_bytes = out_len and go to WAIT_SQ.
- IDLE, start=0: stay in IDLE.
- start outside IDLE is ignored.
- WAIT_SQ: when squeeze=1, capture state_rate into a snapshot register, set word_idx=0, go to STREAM. The first dout_valid is asserted the following cycle, so minimum start-to-first-valid latency is 2 cycles.
- STREAM:
  - dout = snapshot word word_idx, registered.
  - dout_valid stays high until the transfer.
  - dout, dout_valid and dout_last must not change while dout_valid & !dout_ready.
- On each transfer:
  - rem_bytes -= min(8, rem_bytes).
  - If rem_bytes was <=8, this was the last word -> DONE.
  - Else if word_idx==16, the block is exhausted -> assert perm_req for one cycle and go to PERM_WAIT.
  - Else word_idx+1, and the next word is valid on the following cycle (back-to-back throughput of 1 word/cycle).
- dout_last = dout_valid & (rem_bytes <= 8).
- Partial final word: only the low rem_bytes bytes are meaningful. Handling of the unused bytes is set by the optional feature.
- PERM_WAIT: dout_valid=0. On perm_done (squeeze still high), re-snapshot state_rate, set word_idx=0 and go to STREAM. A perm_done outside PERM_WAIT is ignored.
- DONE: done=1 for exactly one cycle, then IDLE. busy falls in the IDLE cycle.
- Arithmetic: rem_bytes is LEN_W bits and never underflows. word_idx is 5 bits, range 0..16, and never wraps past 16.
- Maximum output is 65535 bytes, which requires 481 permutation requests.

Optional Feature:
Macro SQUEEZE_KEEP_EN.
- Defined: adds output port dout_keep[7:0]. It is 0xFF on non-final words, and on the final word it is (1<<rem_bytes)-1, e.g. 0x01 for 1 byte. dout carries the raw snapshot bytes unmasked. dout_keep resets to 0.
- Undefined: there is no dout_keep port. Unused bytes of the final word are forced to zero on dout.

Test Plan:
- out_len=32, squeeze=1 with a known state_rate, dout_ready=1 -> 4 words equal to state_rate words 0..3 on consecutive cycles; dout_last on the 4th; done 1 cycle later; perm_req never asserted.
- out_len=136 -> 17 words; dout_last on word 16; no perm_req.
- out_len=137 -> 17 words, then a 1-cycle perm_req. Drive perm_done 30 cycles later with a new state_rate -> 1 word equal to new word 0. Byte 0 is valid (keep=0x01, or bytes 7:1 zeroed); dout_last=1.
- Backpressure: out_len=32, dout_ready low for 3 cycles while word 2 is valid -> dout, dout_valid and dout_last are stable; word 2 transfers once ready rises; order is preserved.
- out_len=0 -> no dout_valid; done 1 cycle after DONE entry; busy high for exactly 1 cycle.
- Reset asserted during word 5 of out_len=64 -> all outputs 0 on the same edge, no done. A following start with out_len=8 behaves normally.
